// File: rtl/rect_fill_arbiter.sv
// rect_fill_arbiter: round-robin arbiter that clips and rasterises solid rectangles onto one frame-buffer write port
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   req_i               per-requester draw request, held until ack_o
//   rect_x_i/rect_y_i   packed top-left corner per requester (8/7 bits each)
//   rect_w_i/rect_h_i   packed size per requester (8/7 bits each)
//   rect_color_i        packed fill colour per requester
//   draw_enable_i       writes allowed this cycle; low stalls rasterisation
//   ack_o               one-cycle completion pulse to the granted requester
//   busy_o              an operation is in flight
//   wr_en_o/wr_addr_o/wr_data_o  registered frame-buffer write port
module rect_fill_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int ADDR_W    = 15,
    parameter int COLOR_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*8-1:0]       rect_x_i,
    input  logic [NUM_REQ*7-1:0]       rect_y_i,
    input  logic [NUM_REQ*8-1:0]       rect_w_i,
    input  logic [NUM_REQ*7-1:0]       rect_h_i,
    input  logic [NUM_REQ*COLOR_W-1:0] rect_color_i,
    input  logic                       draw_enable_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       busy_o,
    output logic                       wr_en_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [COLOR_W-1:0]         wr_data_o
);
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] X_MAX = 9'(FB_WIDTH);
    localparam logic [7:0] Y_MAX = 8'(FB_HEIGHT);

    // ARB is the one-cycle gap between sampling requests and loading operands
    typedef enum logic [2:0] {IDLE, ARB, LOAD, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d, last_q, last_d, pick_lo, pick_hi;
    logic                hi_found;
    logic [7:0]          x_q, x_d, cx_q, cx_d, sx, sw;
    logic [6:0]          cy_q, cy_d, sy, sh;
    logic [8:0]          xe_q, xe_d, xsum;
    logic [7:0]          ye_q, ye_d, ysum;
    logic [COLOR_W-1:0]  color_q, color_d, sc, wr_data_q, wr_data_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                empty, row_end, last_row;

    // Round-robin: lowest requester above last_q wins, else lowest overall
    always_comb begin
        pick_lo  = '0;
        pick_hi  = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) pick_lo = GW'(i);
            if (req_i[i] && i > int'(last_q)) begin
                pick_hi  = GW'(i);
                hi_found = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sx = '0;
        sy = '0;
        sw = '0;
        sh = '0;
        sc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sx = rect_x_i[8*i +: 8];
                sy = rect_y_i[7*i +: 7];
                sw = rect_w_i[8*i +: 8];
                sh = rect_h_i[7*i +: 7];
                sc = rect_color_i[COLOR_W*i +: COLOR_W];
            end
        end
    end

    // Clip against the screen with widened sums so x+w / y+h cannot wrap
    assign xsum     = {1'b0, sx} + {1'b0, sw};
    assign ysum     = {1'b0, sy} + {1'b0, sh};
    assign empty    = ({1'b0, sx} >= X_MAX) | ({1'b0, sy} >= Y_MAX) | (sw == 8'd0) | (sh == 7'd0);
    assign row_end  = {1'b0, cx_q} == xe_q - 9'd1;
    assign last_row = {1'b0, cy_q} == ye_q - 8'd1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        x_d       = x_q;
        xe_d      = xe_q;
        ye_d      = ye_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        color_d   = color_q;
        ack_d     = '0;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (|req_i) begin
                    grant_d = hi_found ? pick_hi : pick_lo;
                    state_d = ARB;
                end
            end
            ARB: begin
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                x_d     = sx;
                xe_d    = xsum > X_MAX ? X_MAX : xsum;
                ye_d    = ysum > Y_MAX ? Y_MAX : ysum;
                cx_d    = sx;
                cy_d    = sy;
                color_d = sc;
                state_d = empty ? DONE : FILL;
            end
            FILL: begin
                if (draw_enable_i) begin
                    wr_en_d   = 1'b1;
                    // row*160 as (row<<7)+(row<<5)
                    wr_addr_d = ADDR_W'({cy_q, 7'b0}) + ADDR_W'({cy_q, 5'b0}) + ADDR_W'(cx_q);
                    wr_data_d = color_q;
                    cx_d      = row_end ? x_q : cx_q + 8'd1;
                    cy_d      = row_end ? cy_q + 7'd1 : cy_q;
                    state_d   = row_end && last_row ? DONE : FILL;
                end
            end
            DONE: begin
                ack_d[grant_q] = 1'b1;
                last_d         = grant_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            x_q       <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            color_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            x_q       <= x_d;
            xe_q      <= xe_d;
            ye_q      <= ye_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            color_q   <= color_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
endmodule

// File: doc/rect_fill_arbiter.md
Name: rect_fill_arbiter

Overview:
- Shares the single frame-buffer write port among NUM_REQ sprite requesters (player, customers, cups, erase passes).
- Each requester asks for a solid rectangle in virtual 160x120 coordinates. The block arbitrates round-robin, clips the rectangle to the screen, and rasterises it into one address/data write per cycle.
- Its write outputs drive the vga_frame_driver write port (mem_address / mem_data / write_a_pixel).
- draw_enable gates writes, so the game can restrict drawing to a window such as vertical blanking.

Parameters:
- NUM_REQ, 4, number of requesters.
- FB_WIDTH, 160, virtual frame width in pixels.
- FB_HEIGHT, 120, virtual frame height in pixels.
- ADDR_W, 15, write address width.
- COLOR_W, 24, pixel data width (RGB888).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester draw request; level, held until ack.
- rect_x  in  NUM_REQ*8  packed left column; requester i uses bits [8i+7:8i].
- rect_y  in  NUM_REQ*7  packed top row.
- rect_w  in  NUM_REQ*8  packed width in pixels.
- rect_h  in  NUM_REQ*7  packed height in pixels.
- rect_color  in  NUM_REQ*COLOR_W  packed fill colour.
- draw_enable  in  1  writes permitted this cycle; low stalls rasterisation.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  an operation is in progress.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address = row*FB_WIDTH + col.
- wr_data  out  COLOR_W  write data.

Behaviour:
- Reset (rst=0, async): state=IDLE; ack, busy and wr_en = 0; wr_addr and wr_data = 0; last_grant = NUM_REQ-1, so req[0] wins first.
- Reset mid-operation aborts immediately: no further writes, no ack.
- All outputs are registered. Edges are numbered E0, E1, ...

State machine:
- IDLE: if any req bit is high at E0, grant the first set bit searching from last_grant+1 upward with wrap. Latch the grant index; go to LOAD at E1. busy is high from E1 onward.
- LOAD: latch the granted x, y, w, h and color.
  - Clip: x_end = min(x+w, FB_WIDTH); y_end = min(y+h, FB_HEIGHT). Use 9-bit intermediates, no overflow.
  - Empty if x >= FB_WIDTH, y >= FB_HEIGHT, w == 0 or h == 0. Empty goes to DONE; otherwise load cursor cx=x, cy=y and go to FILL at E2.
- FILL, each cycle:
  - draw_enable=1: register wr_en=1, wr_addr=cy*160+cx, wr_data=color. Compute cy*160 as (cy<<7)+(cy<<5); maximum address is 19199.
  - Cursor advance: if cx == x_end-1, set cx=x and cy=cy+1; otherwise cx=cx+1.
  - After issuing pixel (x_end-1, y_end-1), go to DONE.
  - draw_enable=0: register wr_en=0 and hold the cursor. No pixel is lost or duplicated.
- DONE: register ack[grant]=1 for exactly one cycle; set last_grant=grant; go to IDLE. busy falls together with the ack pulse ending.

Timing and handshake:
- An unstalled N-pixel rectangle has wr_en high in the cycles after E3 .. E(N+2). ack is high in the cycle immediately after the last wr_en cycle.
- An empty rectangle has ack high in the cycle after E3, with zero writes.
- Requester operands must stay stable from the req assertion through LOAD. Changes after LOAD are ignored.
- req dropping mid-operation does not cancel it; ack is still issued.
- A requester still asserting req in the cycle after its ack is re-arbitrated normally. Round-robin guarantees that each waiting requester is served within NUM_REQ operations.
- Simultaneous requests are resolved only in IDLE; one operation is in flight at a time.
- Writes are one pixel per cycle. Pixels are issued in raster order: row-major, left to right, then top to bottom.

Test Plan:
- Single request: req[0] with (x=10, y=5, w=2, h=2, color=7F2B0A) -> addresses 810, 811, 970, 971 in the cycles after E3..E6, data 7F2B0A; ack[0] for one cycle after E7; busy=0 afterwards.
- Round-robin: req=4'b1111 held -> acks in order 0, 1, 2, 3. Then with req=4'b1001 -> next grant is 0, then 3, then 0.
- Clipping: x=158, w=5, y=118, h=4 -> only addresses 19038, 19039, 19198, 19199 written. x=200 -> zero writes, ack after E3.
- Zero size: w=0 (and separately h=0) -> no wr_en pulses; single ack; busy high only E1..ack.
- Stall: 3x1 rectangle at (0,0) with draw_enable low for 5 cycles after the first write -> writes 0, 1, 2 exactly once each, in order; ack delayed by 5 cycles.
- Reset mid-fill: assert rst=0 during the 2nd pixel of a 4x4 rectangle -> wr_en, ack and busy go 0 asynchronously. After release with req[1] pending -> req[1] is served first.
